// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU with flags, internal accumulator and
// valid/ready handshakes; stage 1 captures operands, stage 2 computes and registers.
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic [3:0]       out_flags
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
      OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_ACC = 3'd7
   } op_e;

   logic             s1_valid_q;
   logic [WIDTH-1:0] a_q, b_q;
   op_e              op_q;
   logic             clr_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] y_q, acc_q;
   logic [3:0]       flags_q;

   logic             s1_adv, s2_adv;
   logic [WIDTH-1:0] y_d, acc_d, acc_base, sub_r;
   logic [3:0]       flags_d;
   logic [WIDTH:0]   add_r, acc_r, shl_r, shr_r;
   logic [SHW-1:0]   shamt;
   logic             carry, ovf;

   assign s2_adv    = !out_valid_q || out_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign out_y     = y_q;
   assign out_flags = flags_q;

   // Shifts are done one bit wider so the last bit shifted out lands in the extra bit.
   always_comb begin
      acc_base = clr_q ? '0 : acc_q;
      add_r    = {1'b0, a_q} + {1'b0, b_q};
      acc_r    = {1'b0, acc_base} + {1'b0, a_q};
      sub_r    = a_q - b_q;
      shamt    = b_q[SHW-1:0];
      shl_r    = {1'b0, a_q} << shamt;
      shr_r    = {a_q, 1'b0} >> shamt;
      y_d      = '0;
      carry    = 1'b0;
      ovf      = 1'b0;
      acc_d    = acc_base;
      case (op_q)
         OP_ADD: begin
            y_d   = add_r[WIDTH-1:0];
            carry = add_r[WIDTH];
            ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            y_d   = sub_r;
            carry = a_q < b_q;
            ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: y_d = a_q & b_q;
         OP_OR:  y_d = a_q | b_q;
         OP_XOR: y_d = a_q ^ b_q;
         OP_SHL: begin
            y_d   = shl_r[WIDTH-1:0];
            carry = shl_r[WIDTH];
         end
         OP_SHR: begin
            y_d   = shr_r[WIDTH:1];
            carry = shr_r[0];
         end
         OP_ACC: begin
            y_d   = acc_r[WIDTH-1:0];
            carry = acc_r[WIDTH];
            ovf   = (acc_base[WIDTH-1] == a_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
            acc_d = y_d;
         end
         default: y_d = '0;
      endcase
      flags_d = {ovf, y_d[WIDTH-1], carry, (y_d == '0)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
         clr_q      <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op_e'(op);
            clr_q <= in_clr;
         end
      end
   end

   // Bubbles still advance into stage 2 (dropping out_valid) but leave y/acc untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
      end else if (s2_adv) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            y_q     <= y_d;
            flags_q <= flags_d;
            acc_q   <= acc_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): reference model fills an expected
// queue on each accepted input; the monitor pops and compares on each output.
module tb_alu_pipe;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_clr, out_valid, out_ready;
   logic [7:0] a, b, out_y;
   logic [2:0] op;
   logic [3:0] out_flags;

   alu_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .in_clr(in_clr), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op; logic [7:0] a, b; logic clr;
      bit chk; logic [7:0] ey; logic [3:0] ef;
   } stim_t;
   typedef struct {
      logic [7:0] y; logic [3:0] f;
      bit chk; logic [7:0] ey; logic [3:0] ef; int cyc;
   } exp_t;

   stim_t      stim[$];
   exp_t       sb[$];
   logic [7:0] acc_m;
   int         n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic add(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic c, input bit k, input logic [7:0] ey, input logic [3:0] ef);
      stim_t s;
      s.op = o; s.a = aa; s.b = bb; s.clr = c; s.chk = k; s.ey = ey; s.ef = ef;
      stim.push_back(s);
   endtask

   task automatic add_rand(input int n);
      for (int i = 0; i < n; i++)
         add(3'($urandom_range(7)), 8'($urandom), 8'($urandom), $urandom_range(7) == 0, 0, 8'h0, 4'h0);
   endtask

   // Reference model; flags are {ovf, neg, carry, zero}.
   task automatic mdl(input stim_t s, output logic [7:0] y, output logic [3:0] f);
      logic [8:0] t;
      logic [7:0] base;
      logic       c, v;
      int         n;
      base = s.clr ? 8'h00 : acc_m;
      c = 1'b0; v = 1'b0; y = 8'h00;
      n = int'(s.b[2:0]);
      case (s.op)
         3'd0: begin t = {1'b0, s.a} + {1'b0, s.b}; y = t[7:0]; c = t[8];
                  v = (s.a[7] == s.b[7]) && (y[7] != s.a[7]); end
         3'd1: begin y = s.a - s.b; c = (s.a < s.b);
                  v = (s.a[7] != s.b[7]) && (y[7] != s.a[7]); end
         3'd2: y = s.a & s.b;
         3'd3: y = s.a | s.b;
         3'd4: y = s.a ^ s.b;
         3'd5: begin y = s.a << n; if (n != 0) c = s.a[8-n]; end
         3'd6: begin y = s.a >> n; if (n != 0) c = s.a[n-1]; end
         default: begin t = {1'b0, base} + {1'b0, s.a}; y = t[7:0]; c = t[8];
                     v = (base[7] == s.a[7]) && (y[7] != s.a[7]); end
      endcase
      if (s.op == 3'd7) acc_m = y;
      else if (s.clr) acc_m = 8'h00;
      f = {v, y[7], c, (y == 8'h00)};
   endtask

   // rdy_mode: 0 always ready, 1 fixed 1,0,0,1,1,0,1 pattern, 2 random.
   task automatic run(input int rdy_mode, input bit gaps, input bit tput);
      int         cyc = 0, idx = 0, first_out = -1, last_out = -1, nout = 0;
      bit         held = 0;
      logic [7:0] hy = 8'h00;
      logic [6:0] pat = 7'b1011001;
      exp_t       e;
      while ((idx < stim.size() || sb.size() > 0) && cyc < 2000) begin
         @(posedge clk); #1;
         if (idx < stim.size() && !(gaps && $urandom_range(3) == 0)) begin
            in_valid = 1'b1; op = stim[idx].op; a = stim[idx].a;
            b = stim[idx].b; in_clr = stim[idx].clr;
         end else begin
            in_valid = 1'b0; op = 3'd7; a = 8'($urandom); b = 8'($urandom); in_clr = 1'b1;
         end
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = pat[cyc % 7];
            default: out_ready = 1'($urandom_range(1));
         endcase
         @(negedge clk);
         chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
         if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_y", out_y, hy);
         end
         held = out_valid && !out_ready;
         hy   = out_y;
         if (sb.size() == 0) chk("no_spurious", out_valid, 0);
         else if (out_valid && out_ready) begin
            e = sb.pop_front();
            chk("y", out_y, e.y);
            chk("flags", out_flags, e.f);
            if (e.chk) begin
               chk("dir_y", out_y, e.ey);
               chk("dir_flags", out_flags, e.ef);
            end
            if (tput) chk("latency", cyc, e.cyc + 2);
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            nout++;
         end
         if (in_valid && in_ready) begin
            e.chk = stim[idx].chk; e.ey = stim[idx].ey; e.ef = stim[idx].ef; e.cyc = cyc;
            mdl(stim[idx], e.y, e.f);
            sb.push_back(e);
            idx++;
         end
         cyc++;
      end
      if (cyc >= 2000) chk("timeout", cyc, 0);
      if (tput) begin
         chk("tput_count", nout, 16);
         chk("tput_span", last_out - first_out, 15);
      end
      in_valid = 1'b0;
      stim.delete();
   endtask

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = 8'h00; b = 8'h00; op = 3'd0; in_clr = 1'b0; acc_m = 8'h00;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_flags", out_flags, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;

      // Directed arithmetic, logic, shift and accumulator vectors.
      add(3'd0, 8'hFF, 8'h01, 0, 1, 8'h00, 4'b0011);
      add(3'd0, 8'h7F, 8'h01, 0, 1, 8'h80, 4'b1100);
      add(3'd1, 8'h01, 8'h03, 0, 1, 8'hFE, 4'b0110);
      add(3'd4, 8'hA5, 8'hFF, 0, 1, 8'h5A, 4'b0000);
      add(3'd5, 8'h81, 8'h01, 0, 1, 8'h02, 4'b0010);
      add(3'd6, 8'h81, 8'h09, 0, 1, 8'h40, 4'b0010);
      add(3'd5, 8'h3C, 8'h00, 0, 1, 8'h3C, 4'b0000);
      add(3'd7, 8'd10, 8'h55, 0, 1, 8'd10, 4'b0000);
      add(3'd7, 8'd20, 8'h00, 0, 1, 8'd30, 4'b0000);
      add(3'd7, 8'd30, 8'h00, 0, 1, 8'd60, 4'b0000);
      add(3'd7, 8'd7,  8'h00, 1, 1, 8'd7,  4'b0000);
      add(3'd2, 8'hF0, 8'h0F, 1, 1, 8'h00, 4'b0001);
      add(3'd7, 8'd3,  8'h00, 0, 1, 8'd3,  4'b0000);
      run(0, 1, 0);

      add_rand(6);
      run(1, 0, 0);

      add_rand(40);
      run(2, 1, 0);

      add_rand(16);
      run(0, 0, 1);

      // Fill both stages under backpressure, then reset mid-stream.
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'h11; b = 8'h22; in_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_y", out_y, 0);
      chk("mid_rst_out_flags", out_flags, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      acc_m = 8'h00;
      add(3'd7, 8'd5, 8'h00, 0, 1, 8'd5, 4'b0000);
      run(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
